// File: rtl/muldiv_hilo_if.sv
// Operand/result bundle between the ALU operand bus and the HI/LO multiply/divide unit.
// The pipeline side drives the request signals; the unit drives status and HI/LO.
interface muldiv_hilo_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             divZero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, A, B, mthi, mtlo, wdata,
    input  busy, done, divZero, hi, lo
  );

  modport slave (
    input  start, op, A, B, mthi, mtlo, wdata,
    output busy, done, divZero, hi, lo
  );
endinterface

// File: rtl/muldiv_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: radix-2 shift-add multiply and
// restoring divide on magnitudes, one bit per cycle, with sign fix-up on the final edge.
module muldiv_hilo #(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input logic          clk,
  input logic          reset_n,
  muldiv_hilo_if.slave bus
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_is_div;
  logic             r_dz;
  logic             r_res_neg;
  logic             r_rem_neg;
  logic [WIDTH-1:0] r_b;      // multiplicand (mul) or divisor (div), as a magnitude
  logic [WIDTH-1:0] r_hi_w;   // upper product half / partial remainder
  logic [WIDTH-1:0] r_lo_w;   // multiplier shifting out / dividend shifting into quotient
  logic             r_busy;
  logic             r_done;
  logic             r_div_zero;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_sub;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic               w_div_by_zero;

  // Signed ops work on magnitudes; the most negative value maps onto itself, which is
  // still the correct unsigned magnitude.
  assign w_abs_a = (bus.op[0] && bus.A[WIDTH-1]) ? -bus.A : bus.A;
  assign w_abs_b = (bus.op[0] && bus.B[WIDTH-1]) ? -bus.B : bus.B;
  assign w_div_by_zero = bus.op[1] && (bus.B == '0);

  // Multiply step: add multiplicand if the current multiplier bit is set, then shift
  // the 65-bit {carry, hi, lo} right by one.
  assign w_sum = {1'b0, r_hi_w} + (r_lo_w[0] ? {1'b0, r_b} : '0);

  // Divide step: bring the next dividend bit into the 33-bit partial remainder and
  // subtract the divisor when it fits. A remainder below the divisor means the
  // difference always fits in WIDTH bits.
  assign w_shift = {r_hi_w, r_lo_w[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_b});
  assign w_sub   = w_shift[WIDTH-1:0] - r_b;

  assign w_prod     = {r_hi_w, r_lo_w};
  assign w_prod_fix = r_res_neg ? -w_prod : w_prod;
  assign w_quo_fix  = r_res_neg ? -r_lo_w : r_lo_w;
  assign w_rem_fix  = r_rem_neg ? -r_hi_w : r_hi_w;

  // NOTE: every state element, datapath included, takes the async reset and is updated
  // with non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_dz       <= 1'b0;
      r_res_neg  <= 1'b0;
      r_rem_neg  <= 1'b0;
      r_b        <= '0;
      r_hi_w     <= '0;
      r_lo_w     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_is_div  <= bus.op[1];
            r_res_neg <= bus.op[0] && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            r_rem_neg <= (bus.op == 2'b11) && bus.A[WIDTH-1];
            r_cnt     <= '0;
            r_hi_w    <= '0;
            r_busy    <= 1'b1;
            r_dz      <= w_div_by_zero;
            if (w_div_by_zero) begin
              // Raw dividend is parked here so FIX can publish it unchanged on HI.
              r_lo_w  <= bus.A;
              r_b     <= bus.B;
              r_state <= S_FIX;
            end else if (bus.op[1]) begin
              r_lo_w  <= w_abs_a;
              r_b     <= w_abs_b;
              r_state <= S_CALC;
            end else begin
              r_lo_w  <= w_abs_b;
              r_b     <= w_abs_a;
              r_state <= S_CALC;
            end
          end else begin
            if (bus.mthi) r_hi <= bus.wdata;
            if (bus.mtlo) r_lo <= bus.wdata;
          end
        end

        S_CALC: begin
          if (r_is_div) begin
            r_hi_w <= w_ge ? w_sub : w_shift[WIDTH-1:0];
            r_lo_w <= {r_lo_w[WIDTH-2:0], w_ge};
          end else begin
            r_hi_w <= w_sum[WIDTH:1];
            r_lo_w <= {w_sum[0], r_lo_w[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(ITER - 1)) r_state <= S_FIX;
        end

        S_FIX: begin
          if (r_dz) begin
            r_hi       <= r_lo_w;
            r_lo       <= '1;
            r_div_zero <= 1'b1;
          end else if (r_is_div) begin
            r_hi       <= w_rem_fix;
            r_lo       <= w_quo_fix;
            r_div_zero <= 1'b0;
          end else begin
            r_hi       <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo       <= w_prod_fix[WIDTH-1:0];
            r_div_zero <= 1'b0;
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.divZero = r_div_zero;
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;

endmodule

// File: doc/muldiv_hilo.md
Name: muldiv_hilo

Overview:
- Multi-cycle multiply/divide unit owning the HI/LO architectural registers.
- Sits directly downstream of the alu operand bus: it takes the same A/B operands and the sign selection, and produces the HI/LO values that MFHI/MFLO writeback consumes.
- Replaces the single-cycle outHI/outLO path for MULT/MULTU/DIV/DIVU with a 32-iteration shift-add / restoring-divide datapath.
- The busy output stalls the pipeline.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- ITER, WIDTH, iteration count. Fixed equal to WIDTH; other values are not supported.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request a mult/div operation (level sampled at the clock edge)
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- A  input  32  multiplicand / dividend
- B  input  32  multiplier / divisor
- mthi  input  1  write wdata into HI
- mtlo  input  1  write wdata into LO
- wdata  input  32  MTHI/MTLO data
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: HI/LO updated this cycle
- divZero  output  1  sticky flag: last completed DIV/DIVU had B==0
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - hi, lo, busy, done, divZero and all internal registers go to 0 immediately, without a clock.
  - Reset asserted mid-operation aborts it; no partial result is written.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 at edge E0 latches operands as |A| and |B| for signed ops, raw values for unsigned ops.
  - The same edge latches resultNeg = A[31]^B[31] (signed only) and remNeg = A[31] (DIV only).
  - Iteration counter is cleared; go to CALC; busy=1 from E0.
- Divide by zero:
  - If op is DIV/DIVU and B==0 at E0, go directly to FIX with hi=A and lo=32'hFFFFFFFF.
  - divZero is set at the FIX edge.
- CALC:
  - One iteration per cycle for 32 cycles (edges E1..E32), then go to FIX.
  - Multiply: 64-bit product accumulator, radix-2 shift-add, LSB first.
  - Divide: restoring division producing 1 quotient bit per cycle, MSB first, with a 33-bit partial remainder.
- FIX (edge E33):
  - Apply sign correction: product negated if resultNeg; quotient negated if resultNeg; remainder negated if remNeg.
  - Write hi/lo: hi = product[63:32] or remainder; lo = product[31:0] or quotient.
  - divZero is updated: 1 for a div-by-zero, 0 for any other completed op.
  - done=1 and busy=0 in the cycle after E33; done returns to 0 next cycle.
  - Return to IDLE. Total latency is 33 edges from accept; divide-by-zero latency is 1 edge.
- Overflow: DIV of 32'h80000000 by 32'hFFFFFFFF gives lo=32'h80000000, hi=0, with no flag.
- start while busy=1: ignored; operands are not re-latched.
- start on the same edge that done asserts: accepted (the unit is IDLE in that cycle).
- mthi/mtlo:
  - In IDLE with no start, the register is written with wdata at the edge.
  - Both asserted together: hi and lo are both written with wdata.
  - Ignored while busy=1.
  - If start and mthi/mtlo coincide in IDLE, start wins and the move is dropped.
- hi/lo hold their value throughout CALC. Old values stay readable until FIX.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- MULTU with A=B=32'hFFFFFFFF, start pulsed 1 cycle -> busy high 33 cycles; then hi=32'hFFFFFFFE, lo=32'h00000001, done pulse exactly 1 cycle.
- MULT with A=32'hFFFFFFFE (-2), B=3 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFFA.
- DIV with A=32'hFFFFFFF9 (-7), B=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1). DIVU with A=100, B=7 -> lo=14, hi=2, divZero=0.
- DIVU with A=100, B=0 -> done the cycle after accept, hi=100, lo=32'hFFFFFFFF, divZero=1. A following MULTU clears divZero at its completion.
- During a MULT:
  - assert start (new operands) and mthi with wdata=32'h12345678 -> both ignored, result unchanged.
  - After done, mtlo with wdata=32'hCAFEF00D -> lo=32'hCAFEF00D next edge.
- Drop reset_n low at cycle 10 of a DIV -> hi, lo, busy, done all 0 immediately. After release, a fresh DIVU 9/3 gives lo=3, hi=0.
